// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the memory-macro command/response
// signals around dmem_arbiter. The arbiter connects through the slave modport;
// the pipeline, debug requester and memory environment use the master modport.
//
// Handshake: a requester raises *_req with its command and holds the command
// stable until the cycle it is accepted (port A: stall_a=0, port B: b_gnt=1).
// Acceptance is decided combinationally in that same cycle, and a granted read
// returns *_rvalid with rdata exactly one cycle later.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // Port A: pipeline memory stage
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  stall_a;
    logic                  a_rvalid;
    // Port B: debug / loader
    logic                  b_req;
    logic                  b_lock;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_gnt;
    logic                  b_rvalid;
    // Shared read data and lock watchdog pulse
    logic [DATA_WIDTH-1:0] rdata;
    logic                  lock_abort;
    // Memory macro side
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output stall_a, a_rvalid,
        input  b_req, b_lock, b_we, b_addr, b_wdata,
        output b_gnt, b_rvalid,
        output rdata, lock_abort,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  stall_a, a_rvalid,
        output b_req, b_lock, b_we, b_addr, b_wdata,
        input  b_gnt, b_rvalid,
        input  rdata, lock_abort,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the pipeline
// (port A, priority) and a debug/loader requester (port B). Port B is kept
// from starving by an aging counter and can lock the memory for bursts,
// bounded by a lock watchdog. Grants and the memory command are combinational
// in the request cycle; read-valid flags are registered one cycle later.
//
// Build option: define DMEM_ARB_RR_EN to replace priority-plus-aging with
// strict round-robin between A and B (lock behaviour unchanged).
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4,
    parameter int LOCK_MAX   = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    dmem_arbiter_if.slave        bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        A_PRIO    = 2'd0,
        B_STARVED = 2'd1,
        B_LOCKED  = 2'd2
    } state_t;

    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_MAX - 1);

    state_t        state;
    logic [LW-1:0] lock_cnt;
    logic          a_gnt;
    logic          b_gnt_i;
    logic          lock_hit;

`ifdef DMEM_ARB_RR_EN
    // 1 = B owned the last contended-or-not grant, so A wins the next tie
    logic          last_owner;
`else
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    logic [WW-1:0] wait_cnt;
`endif

    // Pick this cycle's winner from the current state and both requests
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt_i = 1'b0;
        if (!Rst) begin
            case (state)
                A_PRIO: begin
`ifdef DMEM_ARB_RR_EN
                    if (bus.a_req && bus.b_req) begin
                        a_gnt   = last_owner;
                        b_gnt_i = ~last_owner;
                    end else begin
                        a_gnt   = bus.a_req;
                        b_gnt_i = bus.b_req;
                    end
`else
                    a_gnt   = bus.a_req;
                    b_gnt_i = bus.b_req & ~bus.a_req;
`endif
                end
                B_STARVED: begin
                    b_gnt_i = bus.b_req;
                    a_gnt   = bus.a_req & ~bus.b_req;
                end
                B_LOCKED: begin
                    b_gnt_i = bus.b_req;
                end
                default: begin
                    a_gnt   = 1'b0;
                    b_gnt_i = 1'b0;
                end
            endcase
        end
    end

    // Watchdog fires in the last permitted locked cycle; that B beat still completes
    assign lock_hit = !Rst && (state == B_LOCKED) && (lock_cnt >= LOCK_LAST);

    // Drive the memory command from the winner; idle bus is all zeros
    always_comb begin
        bus.mem_en    = a_gnt | b_gnt_i;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (a_gnt) begin
            bus.mem_we    = bus.a_we;
            bus.mem_addr  = bus.a_addr;
            bus.mem_wdata = bus.a_wdata;
        end else if (b_gnt_i) begin
            bus.mem_we    = bus.b_we;
            bus.mem_addr  = bus.b_addr;
            bus.mem_wdata = bus.b_wdata;
        end
    end

    assign bus.stall_a    = !Rst && bus.a_req && !a_gnt;
    assign bus.b_gnt      = b_gnt_i;
    assign bus.lock_abort = lock_hit;
    assign bus.rdata      = bus.mem_rdata;
    assign dbg_state      = state;

    // Arbitration state, aging/lock counters and read-valid tracking
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= A_PRIO;
            lock_cnt     <= '0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_owner   <= 1'b1;
`else
            wait_cnt     <= '0;
`endif
        end else begin
            bus.a_rvalid <= a_gnt & ~bus.a_we;
            bus.b_rvalid <= b_gnt_i & ~bus.b_we;
`ifdef DMEM_ARB_RR_EN
            if (a_gnt) begin
                last_owner <= 1'b0;
            end else if (b_gnt_i) begin
                last_owner <= 1'b1;
            end
`endif
            case (state)
                A_PRIO: begin
                    if (b_gnt_i && bus.b_lock) begin
                        // The granting beat counts as the first locked cycle
                        state    <= B_LOCKED;
                        lock_cnt <= LW'(1);
`ifndef DMEM_ARB_RR_EN
                        wait_cnt <= '0;
                    end else if (bus.a_req && bus.b_req) begin
                        // Only increments below the threshold, so it saturates
                        if (wait_cnt >= WAIT_LAST) begin
                            state    <= B_STARVED;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WW'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
`endif
                    end
                end
                B_STARVED: begin
`ifndef DMEM_ARB_RR_EN
                    wait_cnt <= '0;
`endif
                    if (b_gnt_i && bus.b_lock) begin
                        state    <= B_LOCKED;
                        lock_cnt <= LW'(1);
                    end else begin
                        state <= A_PRIO;
                    end
                end
                B_LOCKED: begin
                    // b_lock low ends the lock whether or not B is requesting
                    if (lock_hit || !bus.b_lock) begin
                        state    <= A_PRIO;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                default: begin
                    state    <= A_PRIO;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency memory,
// a reference copy of memory contents and a queue of expected read returns.
module tb_dmem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    logic [1:0] dbg_state;

    dmem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4), .LOCK_MAX(16)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // Memory macro model: synchronous write, registered read data
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i) ^ 8'hA5;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata    <= mem[bus.mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] ref_mem [256];
    logic [DW:0]   exp_q[$];   // {owner_is_b, data}
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the registered read return against the oldest expected read
    task automatic check_rv();
        logic [DW:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("a_rvalid", 32'(bus.a_rvalid), 32'(!e[DW]));
            check("b_rvalid", 32'(bus.b_rvalid), 32'(e[DW]));
            check("rdata", 32'(bus.rdata), 32'(e[DW-1:0]));
        end else begin
            check("a_rvalid_idle", 32'(bus.a_rvalid), 32'd0);
            check("b_rvalid_idle", 32'(bus.b_rvalid), 32'd0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                         input logic br, input logic bl, input logic bw,
                         input logic [7:0] ba, input logic [7:0] bd);
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_lock = bl; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
    endtask

    // win: 0 = nobody, 1 = port A, 2 = port B
    task automatic step(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                        input logic br, input logic bl, input logic bw,
                        input logic [7:0] ba, input logic [7:0] bd,
                        input int win, input logic abort_e);
        logic          e_we;
        logic [7:0]    e_addr;
        logic [7:0]    e_wdata;
        @(negedge clk);
        check_rv();
        rst = 1'b0;
        drive(ar, aw, aa, ad, br, bl, bw, ba, bd);
        #1;
        e_we    = (win == 1) ? aw : (win == 2) ? bw : 1'b0;
        e_addr  = (win == 1) ? aa : (win == 2) ? ba : 8'h00;
        e_wdata = (win == 1) ? ad : (win == 2) ? bd : 8'h00;
        check("stall_a", 32'(bus.stall_a), 32'(ar && (win != 1)));
        check("b_gnt", 32'(bus.b_gnt), 32'(win == 2));
        check("mem_en", 32'(bus.mem_en), 32'(win != 0));
        check("mem_we", 32'(bus.mem_we), 32'(e_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        check("lock_abort", 32'(bus.lock_abort), 32'(abort_e));
        if (win == 1) begin
            if (aw) ref_mem[aa] = ad;
            else    exp_q.push_back({1'b0, ref_mem[aa]});
        end else if (win == 2) begin
            if (bw) ref_mem[ba] = bd;
            else    exp_q.push_back({1'b1, ref_mem[ba]});
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b0);
    endtask

    // Hold reset with both ports requesting; everything must stay quiet
    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_rv();
            rst = 1'b1;
            drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h20, 8'hFF);
            #1;
            check("rst_stall_a", 32'(bus.stall_a), 32'd0);
            check("rst_b_gnt", 32'(bus.b_gnt), 32'd0);
            check("rst_mem_en", 32'(bus.mem_en), 32'd0);
            check("rst_mem_we", 32'(bus.mem_we), 32'd0);
            check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
            check("rst_lock_abort", 32'(bus.lock_abort), 32'd0);
            @(posedge clk);
            #1;
            check("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
            check("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
            check("rst_state", 32'(dbg_state), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i) ^ 8'hA5;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_reset(2);
        mem_init = 1'b0;

`ifdef DMEM_ARB_RR_EN
        // Contended reads alternate A, B, A, ... starting with A
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b0, 8'(8'h10 + i), 8'h00, 1'b1, 1'b0, 1'b0, 8'(8'h30 + i), 8'h00,
                 (i % 2 == 0) ? 1 : 2, 1'b0);
        // Uncontended B, then a tie goes back to A
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 2, 1'b0);
        step(1'b1, 1'b0, 8'h41, 8'h00, 1'b1, 1'b0, 1'b0, 8'h42, 8'h00, 1, 1'b0);
        idle();
`else
        // First access after reset: A read of 0x10
        step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 1'b0);
        // Uncontended B write, then A reads it back, then a B read
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 8'h5A, 2, 1'b0);
        idle();
        step(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00, 2, 1'b0);
        idle();

        // Aging: A wins 4 contended cycles (B's write ignored), B wins the 5th
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 1'b1, 8'h50, 8'h77, 1, 1'b0);
        step(1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 1'b1, 8'h50, 8'h77, 2, 1'b0);
        step(1'b1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 1'b1, 8'h51, 8'h33, 1, 1'b0);
        idle();

        // Aging into a 3-beat lock burst (b_lock 1,1,0) while A keeps requesting
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 8'h11, 1, 1'b0);
        step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 8'h11, 2, 1'b0);
        step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 1'b1, 8'h41, 8'h22, 2, 1'b0);
        step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 8'h00, 2, 1'b0);
        step(1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 1'b0);
        idle();

        // Lock watchdog: 16 locked B grants, abort on the 16th, A wins the 17th
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h60, 8'h00, 2, 1'b0);
        for (int i = 1; i < 16; i++)
            step(1'b1, 1'b0, 8'h70, 8'h00, 1'b1, 1'b1, 1'b1, 8'(8'h60 + i), 8'(i), 2, i == 15);
        step(1'b1, 1'b0, 8'h6F, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1, 1'b0);
        idle();

        // Reset in the middle of a lock returns to A priority
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h80, 8'h44, 2, 1'b0);
        step(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81, 8'h55, 2, 1'b0);
        do_reset(1);
        step(1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 8'h82, 8'h66, 1, 1'b0);
        idle();
`endif
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
